// File: rtl/cbus_arbiter.sv
// cbus_arbiter: burst-locked arbiter sharing one cbus between NUM_INPUTS cache masters.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed lowest-index priority.

package cbus_pkg;

  typedef logic [7:0] mlen_t;

  localparam mlen_t MLEN1  = 8'h00;
  localparam mlen_t MLEN2  = 8'h01;
  localparam mlen_t MLEN4  = 8'h03;
  localparam mlen_t MLEN8  = 8'h07;
  localparam mlen_t MLEN16 = 8'h0f;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  localparam int IDX_W = $clog2(NUM_INPUTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  output logic                         busy,
  output logic       [IDX_W-1:0]       grant_idx,
  output logic                         proto_err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grantIdx_q, grantIdx_d;
  mlen_t             beatCnt_q, beatCnt_d;
  logic              protoErr_q, protoErr_d;

  logic [NUM_INPUTS-1:0] reqValid;
  logic                  anyValid;
  logic [IDX_W-1:0]      winnerIdx;

  always_comb begin
    reqValid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      reqValid[IDX_W'(i)] = ireqs[IDX_W'(i)].valid;
    end
  end

  assign anyValid = |reqValid;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  // Until the first grant after reset the search starts at index 0 inclusive.
  logic rrStarted_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rrStarted_q <= 1'b0;
    end else if (state_q == IDLE && anyValid) begin
      rrStarted_q <= 1'b1;
    end
  end

  always_comb begin
    int  cand;
    logic found;
    winnerIdx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = rrStarted_q ? ((int'(grantIdx_q) + 1 + k) % NUM_INPUTS) : k;
      if (!found && reqValid[IDX_W'(cand)]) begin
        winnerIdx = IDX_W'(cand);
        found     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winnerIdx = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (reqValid[IDX_W'(i)]) begin
        winnerIdx = IDX_W'(i);
      end
    end
  end
`endif

  // Errors compare against the beat count before this beat is added.
  always_comb begin
    state_d    = state_q;
    grantIdx_d = grantIdx_q;
    beatCnt_d  = beatCnt_q;
    protoErr_d = protoErr_q;
    oreq       = '0;
    iresps     = '0;
    case (state_q)
      IDLE: begin
        if (anyValid) begin
          state_d    = BUSY;
          grantIdx_d = winnerIdx;
          beatCnt_d  = '0;
        end
      end
      BUSY: begin
        oreq               = ireqs[grantIdx_q];
        iresps[grantIdx_q] = oresp;
        if (oresp.ready) begin
          beatCnt_d = beatCnt_q + 8'd1;
          if (oresp.last && (beatCnt_q != oreq.len)) begin
            protoErr_d = 1'b1;
          end
          if (!oresp.last && (beatCnt_q == oreq.len)) begin
            protoErr_d = 1'b1;
          end
          if (oresp.last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grantIdx_q <= '0;
      beatCnt_q  <= '0;
      protoErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grantIdx_q <= grantIdx_d;
      beatCnt_q  <= beatCnt_d;
      protoErr_q <= protoErr_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = grantIdx_q;
  assign proto_err = protoErr_q;

endmodule
